// File: rtl/cpu_pio_pkg.sv
// Shared definitions for the CPU PIO blocks: register map, status layout and pulse FSM states.
package cpu_pio_pkg;

    localparam logic [2:0] ADDR_DATA        = 3'd0;
    localparam logic [2:0] ADDR_PULSE_WIDTH = 3'd1;
    localparam logic [2:0] ADDR_STATUS      = 3'd2;
    localparam logic [2:0] ADDR_READBACK    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET      = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR    = 3'd5;
    localparam logic [2:0] ADDR_PULSE       = 3'd6;

    localparam int unsigned STATUS_BUSY_BIT = 16;

    typedef enum logic {
        IDLE,
        ACTIVE
    } pulse_state_e;

endpackage

// File: rtl/cpu_pio_out_if.sv
// Avalon-MM slave bus bundle for the output PIO (word addressed, 32-bit data).
interface cpu_pio_out_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/cpu_pio_out_pulse_timer.sv
// Pulse timer: holds the inversion mask for a programmed number of clocks, then clears it.
module cpu_pio_out_pulse_timer
    import cpu_pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PW_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] start_mask,
    input  logic [PW_WIDTH-1:0]   width,
    output logic [DATA_WIDTH-1:0] mask,
    output logic                  busy
);

    pulse_state_e          r_state;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [PW_WIDTH-1:0]   r_count;
    logic                  r_busy;
    logic                  w_load;

    // A zero width or zero mask makes the pulse request a no-op in either state.
    assign w_load = start && (width != '0) && (start_mask != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_mask  <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_state <= ACTIVE;
                        r_mask  <= start_mask;
                        r_count <= width;
                        r_busy  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // Retrigger wins over expiry on the same edge.
                    if (w_load) begin
                        r_mask  <= start_mask;
                        r_count <= width;
                    end else if (r_count == PW_WIDTH'(1)) begin
                        r_state <= IDLE;
                        r_mask  <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count - PW_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_mask  <= '0;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mask = r_mask;
    assign busy = r_busy;

endmodule

// File: rtl/cpu_pio_out.sv
// Avalon-MM output PIO: data register with atomic set/clear and a self-timed pulse inversion.
module cpu_pio_out
    import cpu_pio_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter int unsigned           PW_WIDTH    = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_pio_out_if.slave          avs,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic [DATA_WIDTH-1:0] r_data;
    logic [PW_WIDTH-1:0]   r_pulse_width;
    logic [DATA_WIDTH-1:0] r_out_port;
    logic [31:0]           r_readdata;

    logic                  w_wr;
    logic                  w_start;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_mask;
    logic                  w_busy;
    logic [31:0]           w_status;
    logic [31:0]           w_rd_value;
    logic                  w_unused_wdata;

    assign w_wr    = avs.chipselect & ~avs.write_n;
    assign w_wdata = avs.writedata[DATA_WIDTH-1:0];
    assign w_start = w_wr && (avs.address == ADDR_PULSE);

    assign w_unused_wdata = &{1'b0, avs.writedata};

    cpu_pio_out_pulse_timer #(
        .DATA_WIDTH (DATA_WIDTH),
        .PW_WIDTH   (PW_WIDTH)
    ) u_pulse_timer (
        .clk        (clk),
        .reset      (reset),
        .start      (w_start),
        .start_mask (w_wdata),
        .width      (r_pulse_width),
        .mask       (w_mask),
        .busy       (w_busy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data        <= RESET_VALUE;
            r_pulse_width <= PW_WIDTH'(1);
        end else if (w_wr) begin
            case (avs.address)
                ADDR_DATA:        r_data        <= w_wdata;
                ADDR_PULSE_WIDTH: r_pulse_width <= avs.writedata[PW_WIDTH-1:0];
                ADDR_OUTSET:      r_data        <= r_data | w_wdata;
                ADDR_OUTCLEAR:    r_data        <= r_data & ~w_wdata;
                default:          ;
            endcase
        end
    end

    always_comb begin
        w_status                  = '0;
        w_status[15:0]            = 16'(w_mask);
        w_status[STATUS_BUSY_BIT] = w_busy;
    end

    always_comb begin
        w_rd_value = '0;
        case (avs.address)
            ADDR_DATA:        w_rd_value = 32'(r_data);
            ADDR_PULSE_WIDTH: w_rd_value = 32'(r_pulse_width);
            ADDR_STATUS:      w_rd_value = w_status;
            ADDR_READBACK:    w_rd_value = 32'(r_out_port);
            default:          w_rd_value = '0;
        endcase
    end

    // Read data is sampled every cycle regardless of chipselect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_port <= RESET_VALUE;
            r_readdata <= '0;
        end else begin
            r_out_port <= r_data ^ w_mask;
            r_readdata <= w_rd_value;
        end
    end

    assign out_port     = r_out_port;
    assign avs.readdata = r_readdata;

endmodule

// File: tb/tb_cpu_pio_out.sv
// Self-checking bench for cpu_pio_out: cycle-stamped scoreboard of expected out_port and readdata.
module tb_cpu_pio_out;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] out_port;

    cpu_pio_out_if bus ();

    cpu_pio_out #(
        .DATA_WIDTH  (16),
        .PW_WIDTH    (16),
        .RESET_VALUE (16'h0000)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .avs      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int unsigned due;
        logic [31:0] exp;
        bit          is_rd;
    } sb_item_t;

    sb_item_t    sb[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input string tag, input int unsigned off, input logic [31:0] exp, input bit is_rd);
        sb_item_t it;
        it.tag   = tag;
        it.due   = cyc + off;
        it.exp   = exp;
        it.is_rd = is_rd;
        sb.push_back(it);
    endtask

    task automatic exp_out(input string tag, input int unsigned off, input logic [15:0] v);
        push(tag, off, 32'(v), 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check_eq(sb[i].tag, sb[i].is_rd ? bus.readdata : 32'(out_port), sb[i].exp);
                sb.delete(i);
            end
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] e);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        push(tag, 1, e, 1'b1);
        tick();
        bus.chipselect = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // Reset
        reset = 1'b1;
        tick();
        exp_out("rst_out", 1, 16'h0000);
        push("rst_rd", 1, 32'h0, 1'b1);
        tick();
        reset = 1'b0;
        rd("rst_pw", 3'd1, 32'h0000_0001);
        rd("rst_status", 3'd2, 32'h0000_0000);

        // Data, set, clear
        wr(3'd0, 32'h0000_00F0);
        exp_out("data_wr", 1, 16'h00F0);
        wr(3'd4, 32'h0000_0003);
        exp_out("outset", 1, 16'h00F3);
        wr(3'd5, 32'h0000_0030);
        exp_out("outclear", 1, 16'h00C3);
        tick();
        rd("readback", 3'd3, 32'h0000_00C3);
        rd("data_rd", 3'd0, 32'h0000_00C3);

        // Pulse timing: 5 cycles of inversion
        wr(3'd1, 32'd5);
        wr(3'd0, 32'h0);
        wr(3'd6, 32'h0000_0101);
        for (int unsigned k = 1; k <= 5; k++) exp_out("pulse_on", k, 16'h0101);
        exp_out("pulse_off", 6, 16'h0000);
        for (int k = 0; k < 5; k++) rd("pulse_status", 3'd2, 32'h0001_0101);
        rd("pulse_status_idle", 3'd2, 32'h0);

        // Retrigger on the 3rd active cycle
        wr(3'd1, 32'd4);
        wr(3'd6, 32'h0000_0001);
        exp_out("retrig_a", 1, 16'h0001);
        exp_out("retrig_a", 2, 16'h0001);
        for (int unsigned k = 3; k <= 6; k++) exp_out("retrig_b", k, 16'h0002);
        exp_out("retrig_end", 7, 16'h0000);
        tick();
        wr(3'd6, 32'h0000_0002);
        tick();
        tick();
        rd("retrig_status", 3'd2, 32'h0001_0002);
        rd("retrig_status", 3'd2, 32'h0001_0002);
        rd("retrig_status_idle", 3'd2, 32'h0);

        // Data change during an active pulse
        wr(3'd0, 32'h0000_00FF);
        wr(3'd1, 32'd3);
        wr(3'd6, 32'h0000_000F);
        exp_out("chg_pre", 1, 16'h00F0);
        exp_out("chg_mid", 2, 16'h0F0F);
        exp_out("chg_mid", 3, 16'h0F0F);
        exp_out("chg_end", 4, 16'h0F00);
        wr(3'd0, 32'h0000_0F00);
        tick();
        tick();
        tick();

        // Zero pulse width makes pulse writes no-ops
        wr(3'd1, 32'd0);
        wr(3'd6, 32'h0000_FFFF);
        exp_out("pw0_out", 1, 16'h0F00);
        exp_out("pw0_out", 2, 16'h0F00);
        rd("pw0_status", 3'd2, 32'h0);
        tick();

        // Reset on the 2nd cycle of a 10-cycle pulse
        wr(3'd1, 32'd10);
        wr(3'd0, 32'h0);
        wr(3'd6, 32'h0000_00FF);
        exp_out("rstmid_on", 1, 16'h00FF);
        tick();
        reset = 1'b1;
        exp_out("rstmid_out", 1, 16'h0000);
        tick();
        reset = 1'b0;
        exp_out("rstmid_hold", 1, 16'h0000);
        rd("rstmid_status", 3'd2, 32'h0);
        rd("rstmid_pw", 3'd1, 32'h0000_0001);

        // Read-only / reserved / write-only addresses
        wr(3'd0, 32'h0000_00A5);
        wr(3'd3, 32'h0000_FFFF);
        wr(3'd7, 32'h0000_FFFF);
        rd("ro_wr_data", 3'd0, 32'h0000_00A5);
        rd("ro_wr_readback", 3'd3, 32'h0000_00A5);
        rd("rsvd_rd", 3'd7, 32'h0);
        rd("wo_rd_outset", 3'd4, 32'h0);
        rd("wo_rd_pulse", 3'd6, 32'h0);
        exp_out("ro_wr_out", 1, 16'h00A5);
        tick();

        check_eq("sb_drain", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
